// File: rtl/hdmi_i2c_cfg_seq_if.sv
// rtl/hdmi_i2c_cfg_seq_if.sv - register table and open-drain I2C pin bundle of the HDMI config sequencer
interface hdmi_i2c_cfg_seq_if #(
    parameter int IDX_W = 6
);
    logic [IDX_W-1:0] lut_index;
    logic [15:0]      lut_data;
    logic             scl_oe;
    logic             sda_oe;
    logic             sda_in;

    modport master (output lut_index, output scl_oe, output sda_oe, input lut_data, input sda_in);
    modport slave  (input lut_index, input scl_oe, input sda_oe, output lut_data, output sda_in);
endinterface

// File: rtl/hdmi_i2c_cfg_seq.sv
// rtl/hdmi_i2c_cfg_seq.sv - HDMI transmitter configuration sequencer with built-in I2C write master
module hdmi_i2c_cfg_seq #(
    parameter int         CLK_FREQ   = 50000000,
    parameter int         I2C_FREQ   = 100000,
    parameter logic [7:0] DEV_ADDR   = 8'h72,
    parameter int         NUM_REGS   = 31,
    parameter int         IDX_W      = 6,
    parameter int         MAX_RETRY  = 3,
    parameter bit         AUTO_START = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               hdmi_tx_int,
    hdmi_i2c_cfg_seq_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [IDX_W-1:0]   fail_index
);
    localparam int Q  = CLK_FREQ / (4 * I2C_FREQ);
    localparam int QW = $clog2(Q);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REGS - 1);

    typedef enum logic [3:0] {IDLE, LOAD, START, SHIFT, ACK, STOP, GAP, DONE, ERR} state_t;

    state_t           state, state_n;
    logic [QW-1:0]    q_cnt;
    logic             tick, run;
    logic [1:0]       ph, ph_n;
    logic [2:0]       bit_cnt, bit_n;
    logic [1:0]       byte_cnt, byte_n;
    logic [23:0]      sr, sr_n;
    logic [IDX_W-1:0] idx, idx_n, fidx_n;
    logic [RW-1:0]    retry, retry_n;
    logic             fail, fail_n, auto_pend, auto_n;
    logic             scl_c, sda_c;

    // The tick counter only runs while a bus phase is active, so every frame starts on a full phase.
    assign run  = state inside {START, SHIFT, ACK, STOP, GAP};
    assign tick = run && (q_cnt == QW'(Q - 1));

    assign bus.lut_index = idx;
    assign bus.scl_oe    = scl_c;
    assign bus.sda_oe    = sda_c;
    assign busy          = !(state inside {IDLE, DONE, ERR});
    assign done          = (state == DONE);
    assign error         = (state == ERR);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            q_cnt      <= '0;
            ph         <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            sr         <= '0;
            idx        <= '0;
            fail_index <= '0;
            retry      <= '0;
            fail       <= 1'b0;
            auto_pend  <= AUTO_START;
        end else begin
            state      <= state_n;
            q_cnt      <= (run && !tick) ? q_cnt + QW'(1) : '0;
            ph         <= ph_n;
            bit_cnt    <= bit_n;
            byte_cnt   <= byte_n;
            sr         <= sr_n;
            idx        <= idx_n;
            fail_index <= fidx_n;
            retry      <= retry_n;
            fail       <= fail_n;
            auto_pend  <= auto_n;
        end
    end

    always_comb begin
        state_n = state;
        ph_n    = tick ? ph + 2'd1 : ph;
        bit_n   = bit_cnt;
        byte_n  = byte_cnt;
        sr_n    = sr;
        idx_n   = idx;
        fidx_n  = fail_index;
        retry_n = retry;
        fail_n  = fail;
        auto_n  = auto_pend;
        scl_c   = 1'b0;
        sda_c   = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (auto_pend || start || !hdmi_tx_int) begin
                    state_n = LOAD;
                    idx_n   = '0;
                    retry_n = '0;
                    auto_n  = 1'b0;
                end
            end
            LOAD: begin
                sr_n    = {DEV_ADDR, bus.lut_data};
                ph_n    = '0;
                bit_n   = '0;
                byte_n  = '0;
                fail_n  = 1'b0;
                state_n = START;
            end
            START: begin
                // p0 idle, p1 SDA falls under high SCL, p2 SCL low before the first data bit
                scl_c = (ph == 2'd2);
                sda_c = (ph != 2'd0);
                if (tick && ph == 2'd2) begin
                    ph_n    = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                scl_c = !ph[1];
                sda_c = !sr[23];
                if (tick && ph == 2'd3) begin
                    sr_n  = {sr[22:0], 1'b0};
                    bit_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_n = ACK;
                end
            end
            ACK: begin
                scl_c = !ph[1];
                if (tick && ph == 2'd2 && bus.sda_in)
                    fail_n = 1'b1;
                if (tick && ph == 2'd3) begin
                    byte_n  = byte_cnt + 2'd1;
                    state_n = (fail || byte_cnt == 2'd2) ? STOP : SHIFT;
                end
            end
            STOP: begin
                scl_c = !ph[1];
                sda_c = (ph != 2'd3);
                if (tick && ph == 2'd3)
                    state_n = GAP;
            end
            GAP: begin
                if (tick && ph == 2'd3) begin
                    if (!fail) begin
                        if (idx == LAST) begin
                            state_n = DONE;
                        end else begin
                            idx_n   = idx + IDX_W'(1);
                            retry_n = '0;
                            state_n = LOAD;
                        end
                    end else if (retry < RW'(MAX_RETRY)) begin
                        retry_n = retry + RW'(1);
                        state_n = LOAD;
                    end else begin
                        fidx_n  = idx;
                        state_n = ERR;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_hdmi_i2c_cfg_seq.sv
// tb/tb_hdmi_i2c_cfg_seq.sv - directed bench: four sequencer instances against behavioural I2C slaves
module tb_hdmi_i2c_cfg_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst_v, start_v, int_v, busy_v, done_v, err_v;
    logic [3:0] pull = '0;
    logic [3:0] scl_oe_v, sda_oe_v;
    logic [5:0] fidx_v [4];
    logic [5:0] idx_v [4];

    hdmi_i2c_cfg_seq_if #(.IDX_W(6)) ifa ();
    hdmi_i2c_cfg_seq_if #(.IDX_W(6)) ifb ();
    hdmi_i2c_cfg_seq_if #(.IDX_W(6)) ifc ();
    hdmi_i2c_cfg_seq_if #(.IDX_W(6)) ifd ();

    function automatic logic [15:0] lut(input logic [5:0] i);
        return {8'h98 + 8'(i), 8'h03 + 8'(i) * 8'd5};
    endfunction

    function automatic logic [31:0] full_fr(input int i);
        return {8'd3, 8'h72, lut(6'(i))};
    endfunction

    assign ifa.lut_data = lut(ifa.lut_index);
    assign ifb.lut_data = lut(ifb.lut_index);
    assign ifc.lut_data = lut(ifc.lut_index);
    assign ifd.lut_data = lut(ifd.lut_index);
    assign ifa.sda_in = ~(ifa.sda_oe | pull[0]);
    assign ifb.sda_in = ~(ifb.sda_oe | pull[1]);
    assign ifc.sda_in = ~(ifc.sda_oe | pull[2]);
    assign ifd.sda_in = ~(ifd.sda_oe | pull[3]);
    assign scl_oe_v = {ifd.scl_oe, ifc.scl_oe, ifb.scl_oe, ifa.scl_oe};
    assign sda_oe_v = {ifd.sda_oe, ifc.sda_oe, ifb.sda_oe, ifa.sda_oe};
    assign idx_v[0] = ifa.lut_index;
    assign idx_v[1] = ifb.lut_index;
    assign idx_v[2] = ifc.lut_index;
    assign idx_v[3] = ifd.lut_index;

    hdmi_i2c_cfg_seq #(.CLK_FREQ(4000000), .I2C_FREQ(100000), .DEV_ADDR(8'h72), .NUM_REGS(31),
                       .IDX_W(6), .MAX_RETRY(3), .AUTO_START(1'b1)) u_a (
        .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .hdmi_tx_int(int_v[0]), .bus(ifa),
        .busy(busy_v[0]), .done(done_v[0]), .error(err_v[0]), .fail_index(fidx_v[0]));
    hdmi_i2c_cfg_seq #(.CLK_FREQ(4000000), .I2C_FREQ(100000), .DEV_ADDR(8'h72), .NUM_REGS(31),
                       .IDX_W(6), .MAX_RETRY(3), .AUTO_START(1'b1)) u_b (
        .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .hdmi_tx_int(int_v[1]), .bus(ifb),
        .busy(busy_v[1]), .done(done_v[1]), .error(err_v[1]), .fail_index(fidx_v[1]));
    hdmi_i2c_cfg_seq #(.CLK_FREQ(4000000), .I2C_FREQ(100000), .DEV_ADDR(8'h72), .NUM_REGS(31),
                       .IDX_W(6), .MAX_RETRY(3), .AUTO_START(1'b1)) u_c (
        .clk(clk), .reset(rst_v[2]), .start(start_v[2]), .hdmi_tx_int(int_v[2]), .bus(ifc),
        .busy(busy_v[2]), .done(done_v[2]), .error(err_v[2]), .fail_index(fidx_v[2]));
    hdmi_i2c_cfg_seq #(.CLK_FREQ(4000000), .I2C_FREQ(100000), .DEV_ADDR(8'h72), .NUM_REGS(1),
                       .IDX_W(6), .MAX_RETRY(3), .AUTO_START(1'b0)) u_d (
        .clk(clk), .reset(rst_v[3]), .start(start_v[3]), .hdmi_tx_int(int_v[3]), .bus(ifd),
        .busy(busy_v[3]), .done(done_v[3]), .error(err_v[3]), .fail_index(fidx_v[3]));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Slave models: b NACKs the value byte of entry 5 once, c NACKs the address at entry 7 forever.
    logic [3:0]  prev_scl = '1, prev_sda = '1, in_fr = '0;
    int          bitc [4] = '{default: 0};
    int          bytec [4] = '{default: 0};
    logic [7:0]  shreg [4];
    logic [7:0]  fb [4][3];
    logic [31:0] flog [4][48];
    int          nfr [4] = '{default: 0};
    bit          b_nacked = 1'b0;
    int          cyc = 0, nrise = 0, fall_t = 0;
    int          rise_t [2] = '{default: 0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic scl, sda, nack;
        for (int g = 0; g < 4; g++) begin
            scl = ~scl_oe_v[g];
            sda = ~(sda_oe_v[g] | pull[g]);
            if (scl && prev_scl[g]) begin
                if (prev_sda[g] && !sda) begin
                    bitc[g] = 0;
                    bytec[g] = 0;
                    in_fr[g] = 1'b1;
                    for (int k = 0; k < 3; k++) fb[g][k] = 8'h00;
                end else if (!prev_sda[g] && sda && in_fr[g]) begin
                    if (nfr[g] < 48) flog[g][nfr[g]] = {8'(bytec[g]), fb[g][0], fb[g][1], fb[g][2]};
                    nfr[g]++;
                    in_fr[g] = 1'b0;
                end
            end
            if (scl && !prev_scl[g] && in_fr[g]) begin
                if (bitc[g] < 8) begin
                    shreg[g] = {shreg[g][6:0], sda};
                    bitc[g]++;
                end else begin
                    if (bytec[g] < 3) fb[g][bytec[g]] = shreg[g];
                    bytec[g]++;
                    bitc[g] = 0;
                end
            end
            if (g == 0 && scl && !prev_scl[g]) begin
                if (nrise < 2) rise_t[nrise] = cyc;
                nrise++;
            end
            if (g == 0 && !scl && prev_scl[g] && nrise == 1) fall_t = cyc;
            if (!scl && prev_scl[g]) begin
                nack = 1'b0;
                if (bitc[g] == 8 && g == 1 && bytec[g] == 2 && idx_v[1] == 6'd5 && !b_nacked) begin
                    nack = 1'b1;
                    b_nacked = 1'b1;
                end
                if (bitc[g] == 8 && g == 2 && bytec[g] == 0 && idx_v[2] == 6'd7) nack = 1'b1;
                pull[g] = (bitc[g] == 8) && !nack;
            end
            prev_scl[g] = scl;
            prev_sda[g] = sda;
        end
    end

    initial begin
        int n0;
        rst_v = '0;
        start_v = '0;
        int_v = '1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl_oe", 32'(ifa.scl_oe), 32'd0);
        check("rst_sda_oe", 32'(ifa.sda_oe), 32'd0);
        check("rst_busy", 32'(busy_v[0]), 32'd0);
        check("rst_done", 32'(done_v[0]), 32'd0);
        check("rst_error", 32'(err_v[0]), 32'd0);
        check("rst_lut_index", 32'(ifa.lut_index), 32'd0);
        check("rst_fail_index", 32'(fidx_v[0]), 32'd0);
        @(negedge clk);
        rst_v = '1;
        repeat (3) @(negedge clk);
        check("auto_busy", 32'(busy_v[0]), 32'd1);

        // NUM_REGS=1 without auto start: idle until start, one frame per start
        repeat (500) @(negedge clk);
        check("d_idle_busy", 32'(busy_v[3]), 32'd0);
        check("d_idle_frames", 32'(nfr[3]), 32'd0);
        check("d_idle_scl", 32'(ifd.scl_oe), 32'd0);
        for (int r = 0; r < 2; r++) begin
            start_v[3] = 1'b1;
            @(negedge clk);
            start_v[3] = 1'b0;
            check($sformatf("d_busy%0d", r), 32'(busy_v[3]), 32'd1);
            check($sformatf("d_done_clr%0d", r), 32'(done_v[3]), 32'd0);
            for (int n = 0; n < 5000 && !done_v[3]; n++) @(negedge clk);
            check($sformatf("d_done%0d", r), 32'(done_v[3]), 32'd1);
            check($sformatf("d_frames%0d", r), 32'(nfr[3]), 32'(r + 1));
            check($sformatf("d_frame%0d", r), flog[3][r], full_fr(0));
        end

        for (int n = 0; n < 20000 && !err_v[2]; n++) @(negedge clk);
        check("c_error", 32'(err_v[2]), 32'd1);
        check("c_fail_index", 32'(fidx_v[2]), 32'd7);
        check("c_done", 32'(done_v[2]), 32'd0);
        check("c_busy", 32'(busy_v[2]), 32'd0);
        check("c_bus", {30'd0, ifc.scl_oe, ifc.sda_oe}, 32'd0);
        repeat (3000) @(negedge clk);
        check("c_frames", 32'(nfr[2]), 32'd11);
        for (int k = 0; k < 11; k++)
            check($sformatf("c_frame%0d", k), flog[2][k], (k < 7) ? full_fr(k) : 32'h0172_0000);

        for (int n = 0; n < 45000 && !done_v[0]; n++) @(negedge clk);
        check("a_done", 32'(done_v[0]), 32'd1);
        check("a_busy", 32'(busy_v[0]), 32'd0);
        check("a_error", 32'(err_v[0]), 32'd0);
        check("a_frames", 32'(nfr[0]), 32'd31);
        for (int k = 0; k < 31; k++) check($sformatf("a_frame%0d", k), flog[0][k], full_fr(k));
        check("scl_period", 32'(rise_t[1] - rise_t[0]), 32'd40);
        check("scl_high", 32'(fall_t - rise_t[0]), 32'd20);

        for (int n = 0; n < 5000 && !done_v[1]; n++) @(negedge clk);
        check("b_done", 32'(done_v[1]), 32'd1);
        check("b_error", 32'(err_v[1]), 32'd0);
        check("b_frames", 32'(nfr[1]), 32'd32);
        for (int k = 0; k < 32; k++)
            check($sformatf("b_frame%0d", k), flog[1][k], full_fr((k < 6) ? k : k - 1));

        // interrupt restart after done, then requests while busy must be ignored
        int_v[0] = 1'b0;
        @(negedge clk);
        int_v[0] = 1'b1;
        check("int_busy", 32'(busy_v[0]), 32'd1);
        check("int_done", 32'(done_v[0]), 32'd0);
        check("int_index", 32'(ifa.lut_index), 32'd0);
        for (int n = 0; n < 3000 && nfr[0] < 32; n++) @(negedge clk);
        check("rerun_frame0", flog[0][31], full_fr(0));
        repeat (300) @(negedge clk);
        start_v[0] = 1'b1;
        int_v[0] = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b0;
        int_v[0] = 1'b1;
        check("ign_index", 32'(ifa.lut_index), 32'd1);
        check("ign_busy", 32'(busy_v[0]), 32'd1);
        for (int n = 0; n < 3000 && nfr[0] < 33; n++) @(negedge clk);
        check("rerun_frame1", flog[0][32], full_fr(1));

        // reset in bit 3 of the register byte of entry 2
        for (int n = 0; n < 3000 && !(bytec[0] == 1 && bitc[0] == 5); n++) @(negedge clk);
        check("mid_reach", 32'(bytec[0] == 1 && bitc[0] == 5), 32'd1);
        rst_v[0] = 1'b0;
        @(posedge clk);
        #1;
        check("mid_scl_oe", 32'(ifa.scl_oe), 32'd0);
        check("mid_sda_oe", 32'(ifa.sda_oe), 32'd0);
        check("mid_busy", 32'(busy_v[0]), 32'd0);
        check("mid_index", 32'(ifa.lut_index), 32'd0);
        @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        n0 = nfr[0];
        for (int n = 0; n < 3000 && nfr[0] <= n0; n++) @(negedge clk);
        check("post_rst_frame", flog[0][n0], full_fr(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hdmi_i2c_cfg_seq.md
Name: hdmi_i2c_cfg_seq

Overview:
- Parametrised next-generation HDMI transmitter configuration sequencer.
- Contains its own open-drain I2C write master (no separate controller clock domain).
- Walks an externally supplied register/value table of NUM_REGS entries, writing each entry to DEV_ADDR.
- Retries NACKed writes, reports done/error status, and re-runs the whole table on start or on a transmitter interrupt (hot-plug).
- Sits between the HDMI pixel pipeline's control logic and the board I2C pins.

Parameters:
- CLK_FREQ, 50000000: clk frequency in Hz.
- I2C_FREQ, 100000: SCL frequency in Hz.
- DEV_ADDR, 8'h72: 8-bit write address byte (R/W bit = 0).
- NUM_REGS, 31: number of table entries; range 1..2**IDX_W.
- IDX_W, 6: width of lut_index.
- MAX_RETRY, 3: retries per entry after the first attempt.
- AUTO_START, 1: when 1, the sequence starts automatically after reset.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-low.
- start, in, 1: single-cycle request to (re)run the table.
- hdmi_tx_int, in, 1: transmitter interrupt, active-low.
- lut_index, out, IDX_W: current table entry.
- lut_data, in, 16: {register, value} for lut_index. Combinational source, valid one clk after lut_index changes.
- scl_oe, out, 1: 1 = pull SCL low, 0 = release.
- sda_oe, out, 1: 1 = pull SDA low, 0 = release.
- sda_in, in, 1: sampled SDA pin.
- busy, out, 1: sequence in progress.
- done, out, 1: all entries written with ACK.
- error, out, 1: an entry exhausted its retries.
- fail_index, out, IDX_W: entry that caused error.

Behaviour:
- Reset (reset=0 on a rising clk edge):
  - scl_oe=0, sda_oe=0, busy=0, done=0, error=0, lut_index=0, fail_index=0, state=IDLE.
  - Takes effect within one clk, including mid-byte; the bus is released immediately and no STOP is issued.
- Tick generator:
  - Counter 0..Q-1 with Q = CLK_FREQ/(4*I2C_FREQ), integer division; Q must be ≥2.
  - One-clk tick when the counter wraps.
  - Each bit is 4 ticks (phases p0..p3). SCL is low in p0/p1 and released in p2/p3.
  - No clock-stretching support.
- Bit timing:
  - SDA changes only at p0.
  - ACK is sampled from sda_in at p2.
  - START: SDA falls at p1 with SCL high, then one low-SCL phase.
  - STOP: SDA low, SCL rises, SDA released at p3.
- Transaction: START, DEV_ADDR, ACK, lut_data[15:8], ACK, lut_data[7:0], ACK, STOP. MSB first. sda_oe=0 during ACK bits.
- States:
  - IDLE: bus released. Go to LOAD on start, or on AUTO_START after reset.
  - LOAD: lut_data is latched into a 24-bit shift register one clk after entry, then go to START.
  - START → SHIFT (8 bits) → ACK, repeated for 3 bytes.
  - ACK: sda_in=1 (NACK) goes to STOP with a fail flag; the remaining bytes are skipped.
  - STOP → GAP (4 ticks, bus idle).
  - GAP:
    - On success: if lut_index==NUM_REGS-1, go to DONE; else lut_index+1, retry count cleared, go to LOAD.
    - On fail: if retry count < MAX_RETRY, increment it and go to LOAD with the same index; else fail_index=lut_index, go to ERR.
  - DONE: done=1, busy=0.
  - ERR: error=1, busy=0, done=0.
- busy=1 in every state except IDLE/DONE/ERR.
- Restart:
  - In IDLE/DONE/ERR, start=1 or hdmi_tx_int=0 (level) clears done/error/retry and sets lut_index=0 → LOAD.
  - While busy, start and hdmi_tx_int are ignored.
  - If start and reset are active together, reset wins.
- lut_index changes only in GAP or on restart, never mid-transaction.

Test Plan:
1. CLK_FREQ=4000000, I2C_FREQ=100000 (Q=10), ACKing slave model:
   - Reset → SCL period 40 clk, high 20 clk.
   - First frame is 72/98/03.
   - 31 frames with lut_index 0..30 in order.
   - Then done=1, busy=0, error=0.
2. Slave NACKs the data byte of index 5 once → index 5 frame appears twice, then 6..30; done=1, error=0.
3. Slave NACKs the address byte at index 7 permanently, MAX_RETRY=3 → exactly 4 attempts at index 7, then error=1, fail_index=7, done=0, scl_oe=sda_oe=0, no index-8 frame.
4. After done, hdmi_tx_int=0 for 1 clk → busy=1, done=0, table re-sent from index 0. hdmi_tx_int pulses while busy cause no restart.
5. reset=0 during bit 3 of the register byte → next clk scl_oe=sda_oe=0 and busy=0. On release with AUTO_START=1, a fresh START is issued at index 0.
6. NUM_REGS=1, AUTO_START=0 → idle until start pulse; one frame, then done=1. A second start after done repeats the frame.
